ebram_mem2r1w: RTL and testbench

Parametrised block-RAM memory with two independent registered read ports and one byte-enabled write port, built to map onto iCE40 EBRAM. It supersedes the fixed dual-read instruction ROM. The pipeline uses it as writable instruction/data memory: port A serves fetch, port B serves load, and the write port serves store or a boot loader. Optional reset-time clearing, read enables for pipeline stalls, an optional second output register and a selectable read-during-write policy are added.

---
 rtl/ebram_mem2r1w_pkg.sv | 18 +
 rtl/ebram_clear_fsm.sv | 38 +++
 rtl/ebram_mem2r1w.sv | 75 +++++++
 tb/tb_ebram_mem2r1w.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ebram_mem2r1w_pkg.sv
// ebram_mem2r1w_pkg: shared encodings, clear-FSM states and byte-merge helper for the ebram slice
package ebram_mem2r1w_pkg;
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  localparam int MERGE_W = 128;
  typedef enum logic [1:0] {IDLE, CLEAR, READY} clr_state_t;
  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]   old_w,
    input logic [MERGE_W-1:0]   new_w,
    input logic [MERGE_W/8-1:0] be
  );
    logic [MERGE_W-1:0] r;
    r = old_w;
    for (int i = 0; i < MERGE_W/8; i++)
      if (be[i]) r[8*i+:8] = new_w[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/ebram_clear_fsm.sv
// ebram_clear_fsm: walks the array writing zeros after reset release and holds busy meanwhile
module ebram_clear_fsm
  import ebram_mem2r1w_pkg::*;
#(
  parameter int DEPTH          = 512,
  parameter int DEPTH_LOG      = 9,
  parameter int CLEAR_ON_RESET = 1
)(
  input  logic                 clk,
  input  logic                 reset,
  output logic                 busy,
  output logic                 clr_we,
  output logic [DEPTH_LOG-1:0] clr_addr
);
  localparam logic [DEPTH_LOG-1:0] LAST = DEPTH_LOG'(DEPTH - 1);
  clr_state_t state, state_n;
  logic [DEPTH_LOG-1:0] cnt, cnt_n;
  logic last;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      if (CLEAR_ON_RESET != 0) state <= IDLE;
      else state <= READY;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  // IDLE already writes word 0 so that the sweep finishes exactly DEPTH edges after release
  always_comb begin
    busy = state != READY;
    clr_we = busy;
    clr_addr = cnt;
    last = cnt == LAST;
    state_n = state;
    if (busy) state_n = last ? READY : CLEAR;
    cnt_n = busy && !last ? cnt + DEPTH_LOG'(1) : cnt;
  end
endmodule

// File: rtl/ebram_mem2r1w.sv
// ebram_mem2r1w: inferred block RAM with two registered read ports and one byte-enabled write port
module ebram_mem2r1w
  import ebram_mem2r1w_pkg::*;
#(
  parameter int DEPTH          = 512,
  parameter int DEPTH_LOG      = 9,
  parameter int WIDTH          = 32,
  parameter int NBYTES         = WIDTH/8,
  parameter int OUT_REG        = 0,
  parameter int RDW_MODE       = RDW_OLD,
  parameter int CLEAR_ON_RESET = 1
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rea,
  input  logic [DEPTH_LOG-1:0] addra,
  output logic [WIDTH-1:0]     douta,
  input  logic                 reb,
  input  logic [DEPTH_LOG-1:0] addrb,
  output logic [WIDTH-1:0]     doutb,
  input  logic                 we,
  input  logic [NBYTES-1:0]    wbe,
  input  logic [DEPTH_LOG-1:0] addrw,
  input  logic [WIDTH-1:0]     dinw,
  output logic                 busy
);
  localparam logic [DEPTH_LOG:0] DEPTH_W = (DEPTH_LOG+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic clr_we, w_en;
  logic [DEPTH_LOG-1:0] clr_addr, w_addr;
  logic [WIDTH-1:0] w_din;
  logic [NBYTES-1:0] w_be;
  logic [1:0] re;
  logic [DEPTH_LOG-1:0] ra [2];
  logic [WIDTH-1:0] dout [2];
  ebram_clear_fsm #(.DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG), .CLEAR_ON_RESET(CLEAR_ON_RESET)) u_clr (
    .clk(clk), .reset(reset), .busy(busy), .clr_we(clr_we), .clr_addr(clr_addr)
  );
  always_comb begin
    w_addr = busy ? clr_addr : addrw;
    w_din = busy ? '0 : dinw;
    w_be = busy ? '1 : wbe;
    w_en = (busy ? clr_we : we) && {1'b0, w_addr} < DEPTH_W;
    re = busy ? 2'b00 : {reb, rea};
    ra[0] = addra;
    ra[1] = addrb;
  end
  assign douta = dout[0];
  assign doutb = dout[1];
  always_ff @(posedge clk)
    if (w_en)
      for (int i = 0; i < NBYTES; i++)
        if (w_be[i]) mem[w_addr][8*i+:8] <= w_din[8*i+:8];
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [WIDTH-1:0] rd, d1, d2;
    logic [MERGE_W-1:0] fwd;
    logic hit, en_q, unused_fwd;
    assign rd = {1'b0, ra[p]} < DEPTH_W ? mem[ra[p]] : '0;
    assign hit = RDW_MODE == RDW_NEW && w_en && w_addr == ra[p];
    assign fwd = byte_merge(MERGE_W'(rd), MERGE_W'(dinw), (MERGE_W/8)'(wbe));
    assign unused_fwd = ^fwd;
    assign dout[p] = OUT_REG != 0 ? d2 : d1;
    // stage 2 follows stage 1 only after an enabled edge, so a stall freezes the pair together
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        d1 <= '0;
        d2 <= '0;
        en_q <= 1'b0;
      end else begin
        en_q <= re[p];
        if (re[p]) d1 <= hit ? fwd[WIDTH-1:0] : rd;
        if (en_q) d2 <= d1;
      end
  end
endmodule

// File: tb/tb_ebram_mem2r1w.sv
// tb_ebram_mem2r1w: two configurations against a word-array model plus directed literal checks
module tb_ebram_mem2r1w;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1, rea = 1'b0, reb = 1'b0, we = 1'b0;
  logic [8:0] addra = '0, addrb = '0, addrw = '0;
  logic [3:0] wbe = '0;
  logic [31:0] dinw = '0;
  logic [31:0] douta0, doutb0, douta1, doutb1;
  logic busy0, busy1;
  int checks = 0, errors = 0;

  ebram_mem2r1w #(.DEPTH(512), .DEPTH_LOG(9), .WIDTH(32), .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .reset(reset), .rea(rea), .addra(addra), .douta(douta0), .reb(reb), .addrb(addrb),
    .doutb(doutb0), .we(we), .wbe(wbe), .addrw(addrw), .dinw(dinw), .busy(busy0));
  ebram_mem2r1w #(.DEPTH(300), .DEPTH_LOG(9), .WIDTH(32), .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .reset(reset), .rea(rea), .addra(addra), .douta(douta1), .reb(reb), .addrb(addrb),
    .doutb(doutb1), .we(we), .wbe(wbe), .addrw(addrw), .dinw(dinw), .busy(busy1));

  function automatic int dep(input int k);
    return k == 0 ? 512 : 300;
  endfunction

  logic [31:0] mm [2][512];
  int bcnt [2];
  logic [31:0] s1a [2], s2a [2], s1b [2], s2b [2];
  bit pa [2], pb [2];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i+:8] = n[8*i+:8];
    return r;
  endfunction

  function automatic logic [31:0] rdval(input int k, input logic [8:0] a, input bit wr);
    if (int'(a) >= dep(k)) return 32'h0;
    if (k == 1 && wr && a == addrw) return merge(mm[k][a], dinw, wbe);
    return mm[k][a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit ready, wr;
      if (reset) begin
        bcnt[k] = dep(k);
        s1a[k] = 0; s2a[k] = 0; s1b[k] = 0; s2b[k] = 0;
        pa[k] = 0; pb[k] = 0;
      end else begin
        ready = bcnt[k] == 0;
        wr = ready && we && int'(addrw) < dep(k);
        if (!ready) begin
          bcnt[k]--;
          if (bcnt[k] == 0) for (int a = 0; a < 512; a++) mm[k][a] = 32'h0;
        end
        if (pa[k]) s2a[k] = s1a[k];
        if (pb[k]) s2b[k] = s1b[k];
        pa[k] = ready && rea;
        pb[k] = ready && reb;
        if (pa[k]) s1a[k] = rdval(k, addra, wr);
        if (pb[k]) s1b[k] = rdval(k, addrb, wr);
        if (wr) mm[k][addrw] = merge(mm[k][addrw], dinw, wbe);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    #2;
    chk("u0_busy", 32'(busy0), 32'(bcnt[0] != 0));
    chk("u1_busy", 32'(busy1), 32'(bcnt[1] != 0));
    chk("u0_douta", douta0, s1a[0]);
    chk("u0_doutb", doutb0, s1b[0]);
    chk("u1_douta", douta1, s2a[1]);
    chk("u1_doutb", doutb1, s2b[1]);
  end

  task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
    addrw = a; dinw = d; wbe = be; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic read_chk(input string nm, input logic [8:0] a, input logic [31:0] e0, input logic [31:0] e1);
    rea = 1'b1; addra = a;
    @(negedge clk);
    rea = 1'b0;
    @(negedge clk);
    chk({nm, "_u0"}, douta0, e0);
    chk({nm, "_u1"}, douta1, e1);
  endtask

  initial begin
    int n0, n1;
    repeat (3) @(negedge clk);
    chk("rst_douta0", douta0, 32'h0);
    chk("rst_doutb1", doutb1, 32'h0);
    chk("rst_busy0", 32'(busy0), 32'h1);
    chk("rst_busy1", 32'(busy1), 32'h1);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n0 = 0; n1 = 0;
    for (int c = 0; c < 1000 && (busy0 || busy1); c++) begin
      if (busy0) n0++;
      if (busy1) n1++;
      @(negedge clk);
    end
    chk("clear_len_u0", n0, 512);
    chk("clear_len_u1", n1, 300);
    read_chk("clr0", 9'd0, 32'h0, 32'h0);
    read_chk("clr255", 9'd255, 32'h0, 32'h0);
    read_chk("clr511", 9'd511, 32'h0, 32'h0);
    wr(9'd5, 32'hAABBCCDD, 4'b1111);
    wr(9'd5, 32'h11223344, 4'b0101);
    read_chk("bytewr", 9'd5, 32'hAA22CC44, 32'hAA22CC44);
    wr(9'd7, 32'h12345678, 4'b1111);
    addrw = 9'd7; dinw = 32'hFFFFFFFF; wbe = 4'b0011; we = 1'b1; rea = 1'b1; addra = 9'd7;
    @(negedge clk);
    we = 1'b0; rea = 1'b0;
    @(negedge clk);
    chk("rdw_old_u0", douta0, 32'h12345678);
    chk("rdw_new_u1", douta1, 32'h1234FFFF);
    read_chk("rdw_after", 9'd7, 32'h1234FFFF, 32'h1234FFFF);
    wr(9'd3, 32'hDEADBEEF, 4'b1111);
    wr(9'd4, 32'h0BADF00D, 4'b1111);
    rea = 1'b1; addra = 9'd3;
    @(negedge clk);
    rea = 1'b0;
    repeat (4) begin
      addra = 9'($urandom_range(0, 511));
      @(negedge clk);
    end
    chk("stall_u0", douta0, 32'hDEADBEEF);
    chk("stall_u1", douta1, 32'hDEADBEEF);
    rea = 1'b1; addra = 9'd4;
    @(negedge clk);
    rea = 1'b0;
    chk("resume_u0", douta0, 32'h0BADF00D);
    chk("resume_u1_lat", douta1, 32'hDEADBEEF);
    @(negedge clk);
    chk("resume_u1", douta1, 32'h0BADF00D);
    wr(9'd10, 32'hA0A0A010, 4'b1111);
    wr(9'd1, 32'hB1B1B101, 4'b1111);
    wr(9'd2, 32'hC2C2C202, 4'b1111);
    rea = 1'b1; reb = 1'b1; addra = 9'd10; addrb = 9'd10;
    @(negedge clk);
    chk("dual10_a0", douta0, 32'hA0A0A010);
    chk("dual10_b0", doutb0, 32'hA0A0A010);
    addra = 9'd1; addrb = 9'd2;
    @(negedge clk);
    rea = 1'b0; reb = 1'b0;
    chk("dual1_a0", douta0, 32'hB1B1B101);
    chk("dual2_b0", doutb0, 32'hC2C2C202);
    chk("dual10_a1", douta1, 32'hA0A0A010);
    chk("dual10_b1", doutb1, 32'hA0A0A010);
    @(negedge clk);
    chk("dual1_a1", douta1, 32'hB1B1B101);
    chk("dual2_b1", doutb1, 32'hC2C2C202);
    wr(9'd144, 32'hCAFEF00D, 4'b1111);
    wr(9'd400, 32'h55555555, 4'b1111);
    read_chk("oor400", 9'd400, 32'h55555555, 32'h0);
    read_chk("oor144", 9'd144, 32'hCAFEF00D, 32'hCAFEF00D);
    for (int i = 0; i < 3000; i++) begin
      bit near;
      near = $urandom_range(0, 1) == 1;
      addra = near ? 9'($urandom_range(0, 7)) : 9'($urandom_range(0, 511));
      addrb = near ? 9'($urandom_range(0, 7)) : 9'($urandom_range(0, 511));
      addrw = near ? 9'($urandom_range(0, 7)) : 9'($urandom_range(0, 511));
      rea = $urandom_range(0, 3) != 0;
      reb = $urandom_range(0, 3) != 0;
      we = $urandom_range(0, 1) == 1;
      wbe = 4'($urandom);
      dinw = $urandom;
      reset = i == 1500;
      @(negedge clk);
    end
    reset = 1'b0; rea = 1'b0; reb = 1'b0; we = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
